// File: rtl/row_window_buf.sv
// row_window_buf: streams one frame of rows and emits registered 3-row windows {top, mid, bot} with top/bottom border handling.
module row_window_buf #(
  parameter int COLS = 512,
  parameter int ROWS = 512,
  parameter int WIDTH = 8,
  parameter int BORDER = 0,
  localparam int L = COLS * WIDTH,
  localparam int CW = $clog2(ROWS) + 1
) (
  input  logic           CLK,
  input  logic           RST,
  input  logic           start,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [L-1:0]   in_row,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [3*L-1:0] out_win,
  output logic [CW-1:0]  out_idx,
  output logic           out_first,
  output logic           out_last,
  output logic           busy,
  output logic           frame_done
);
  typedef enum logic [2:0] {IDLE, LOAD, RUN, FLUSH, DONE} state_t;
  localparam logic [CW-1:0] LAST = CW'(ROWS - 1);
  state_t state, state_nx;
  logic [CW-1:0] cnt;
  logic [L-1:0] top_line, mid_line, edge_row;
  logic slot_free, acc;
  // mid_line holds row 0 when the first window forms and row ROWS-1 at flush,
  // so it doubles as the replicated edge row for both borders.
  always_comb begin
    slot_free = !out_valid || out_ready;
    in_ready = state == LOAD || (state == RUN && slot_free);
    acc = in_valid && in_ready;
    busy = state != IDLE;
    frame_done = state == DONE && !out_valid;
    edge_row = BORDER != 0 ? '0 : mid_line;
    state_nx = state;
    case (state)
      IDLE:    if (start) state_nx = LOAD;
      LOAD:    if (acc) state_nx = RUN;
      RUN:     if (acc && cnt == LAST) state_nx = FLUSH;
      FLUSH:   if (slot_free) state_nx = DONE;
      DONE:    if (!out_valid) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end
  always_ff @(posedge CLK or negedge RST)
    if (!RST) state <= IDLE;
    else state <= state_nx;
  always_ff @(posedge CLK)
    if (acc) begin
      top_line <= mid_line;
      mid_line <= in_row;
    end
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      cnt <= '0;
      out_valid <= 1'b0;
      out_win <= '0;
      out_idx <= '0;
      out_first <= 1'b0;
      out_last <= 1'b0;
    end else begin
      cnt <= state == IDLE ? '0 : cnt + CW'(acc);
      if (acc && state == RUN) begin
        out_valid <= 1'b1;
        out_win <= {cnt == CW'(1) ? edge_row : top_line, mid_line, in_row};
        out_idx <= cnt - CW'(1);
        out_first <= cnt == CW'(1);
        out_last <= 1'b0;
      end else if (state == FLUSH && slot_free) begin
        out_valid <= 1'b1;
        out_win <= {top_line, mid_line, edge_row};
        out_idx <= LAST;
        out_first <= 1'b0;
        out_last <= 1'b1;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_row_window_buf.sv
// tb_row_window_buf: three instances (replicate, zero border, two-row frame) checked against a frame-level scoreboard.
module tb_row_window_buf;
  localparam int COLS = 4;
  localparam int WIDTH = 8;
  localparam int L = COLS * WIDTH;
  logic CLK = 0, RST = 1, start = 0, in_valid = 0, out_ready = 1;
  logic [L-1:0] in_row = '0;
  int total = 0, passed = 0;
  always #5 CLK = ~CLK;
  task automatic check(input bit ok, input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (ok) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask
  for (genvar g = 0; g < 3; g++) begin : gen_dut
    localparam int R = g == 2 ? 2 : 4;
    localparam int B = g == 1 ? 1 : 0;
    localparam int CW = $clog2(R) + 1;
    logic ir, ov, first, last, busy, fd;
    logic [3*L-1:0] win, pwin, ewin;
    logic [CW-1:0] idx, pidx;
    logic [L-1:0] rows [R];
    logic [L-1:0] t, b;
    int cnt = 0, cons = 0, frames = 0;
    bit active = 0, pstall = 0, exp_ir, exp_fd;
    row_window_buf #(.COLS(COLS), .ROWS(R), .WIDTH(WIDTH), .BORDER(B)) u_dut (
      .CLK(CLK), .RST(RST), .start(start), .in_valid(in_valid), .in_ready(ir), .in_row(in_row),
      .out_valid(ov), .out_ready(out_ready), .out_win(win), .out_idx(idx), .out_first(first),
      .out_last(last), .busy(busy), .frame_done(fd));
    // Window k is {row k-1 or top border, row k, row k+1 or bottom border} over the rows accepted this frame.
    always @(negedge CLK) begin
      if (!RST) begin
        check(!(ov | first | last | ir | busy | fd) && win == '0 && idx == '0,
              $sformatf("g%0d reset", g), {ov, first, last, ir, busy, fd}, 0);
        active = 0; cnt = 0; cons = 0; pstall = 0;
      end else begin
        exp_ir = active && (cnt == 0 || (cnt < R && (!ov || out_ready)));
        exp_fd = active && cons == R;
        check(ir == exp_ir, $sformatf("g%0d in_ready", g), ir, exp_ir);
        check(busy == active, $sformatf("g%0d busy", g), busy, active);
        check(fd == exp_fd, $sformatf("g%0d frame_done", g), fd, exp_fd);
        if (pstall) check(ov && win == pwin && idx == pidx, $sformatf("g%0d hold", g), win, pwin);
        if (ov && out_ready) begin
          ewin = '0;
          if (cons < R) begin
            t = cons == 0 ? (B != 0 ? '0 : rows[0]) : rows[cons-1];
            b = cons == R - 1 ? (B != 0 ? '0 : rows[R-1]) : rows[cons+1];
            ewin = {t, rows[cons], b};
          end
          check(cons < R && (cnt == R || cons + 2 <= cnt) && int'(idx) == cons && win == ewin &&
                first == (cons == 0) && last == (cons == R - 1),
                $sformatf("g%0d window idx %0d", g, cons), {idx, first, last, win}, {CW'(cons), 2'b00, ewin});
          cons++;
        end
        pstall = ov && !out_ready; pwin = win; pidx = idx;
        if (exp_ir && in_valid) begin rows[cnt] = in_row; cnt++; end
        if (exp_fd) begin active = 0; cnt = 0; cons = 0; frames++; end
        else if (!active && start) active = 1;
      end
    end
  end
  typedef struct {
    bit st; bit iv; logic [7:0] px;
    bit ov; int idx; logic [7:0] t, m, b;
    bit first, last, ir, busy, fd;
  } vec_t;
  vec_t tbl [8];
  task automatic run_until_done(input bit rnd, input string name);
    for (int i = 0; i < 300; i++) begin
      in_valid = rnd ? 1'($urandom % 2) : 1'b1;
      out_ready = rnd ? ($urandom % 4 != 0) : 1'b1;
      in_row = $urandom;
      start = rnd && ($urandom % 6 == 0);
      @(posedge CLK); #1;
      if (gen_dut[0].fd) begin
        start = 0; in_valid = 0; out_ready = 1;
        @(posedge CLK); #1;
        return;
      end
    end
    check(gen_dut[0].fd, name, gen_dut[0].fd, 1);
    start = 0; in_valid = 0; out_ready = 1;
  endtask
  task automatic pulse_start();
    start = 1;
    @(posedge CLK); #1;
    start = 0;
  endtask
  initial begin
    tbl[0] = '{1, 0, 8'h00, 0, 0, 8'h00, 8'h00, 8'h00, 0, 0, 1, 1, 0};
    tbl[1] = '{0, 1, 8'h01, 0, 0, 8'h00, 8'h00, 8'h00, 0, 0, 1, 1, 0};
    tbl[2] = '{0, 1, 8'h02, 1, 0, 8'h01, 8'h01, 8'h02, 1, 0, 1, 1, 0};
    tbl[3] = '{0, 1, 8'h03, 1, 1, 8'h01, 8'h02, 8'h03, 0, 0, 1, 1, 0};
    tbl[4] = '{0, 1, 8'h04, 1, 2, 8'h02, 8'h03, 8'h04, 0, 0, 0, 1, 0};
    tbl[5] = '{0, 0, 8'h00, 1, 3, 8'h03, 8'h04, 8'h04, 0, 1, 0, 1, 0};
    tbl[6] = '{0, 0, 8'h00, 0, 0, 8'h00, 8'h00, 8'h00, 0, 0, 0, 1, 1};
    tbl[7] = '{0, 0, 8'h00, 0, 0, 8'h00, 8'h00, 8'h00, 0, 0, 0, 0, 0};
    #1 RST = 0;
    repeat (3) @(posedge CLK);
    #1 RST = 1;
    for (int i = 0; i < 8; i++) begin
      start = tbl[i].st; in_valid = tbl[i].iv; in_row = {COLS{tbl[i].px}};
      @(posedge CLK); #1;
      check(gen_dut[0].ov == tbl[i].ov, $sformatf("tbl%0d out_valid", i), gen_dut[0].ov, tbl[i].ov);
      check(gen_dut[0].ir == tbl[i].ir, $sformatf("tbl%0d in_ready", i), gen_dut[0].ir, tbl[i].ir);
      check({gen_dut[0].busy, gen_dut[0].fd} == {tbl[i].busy, tbl[i].fd}, $sformatf("tbl%0d busy/done", i),
            {gen_dut[0].busy, gen_dut[0].fd}, {tbl[i].busy, tbl[i].fd});
      if (tbl[i].ov)
        check(gen_dut[0].win == {{COLS{tbl[i].t}}, {COLS{tbl[i].m}}, {COLS{tbl[i].b}}} &&
              int'(gen_dut[0].idx) == tbl[i].idx && gen_dut[0].first == tbl[i].first && gen_dut[0].last == tbl[i].last,
              $sformatf("tbl%0d window", i), {gen_dut[0].idx, gen_dut[0].first, gen_dut[0].last, gen_dut[0].win},
              {3'(tbl[i].idx), tbl[i].first, tbl[i].last, {COLS{tbl[i].t}}, {COLS{tbl[i].m}}, {COLS{tbl[i].b}}});
    end
    start = 0; in_valid = 0;
    // Back-pressure while window 1 is held: input must stall and the window must not move.
    pulse_start();
    in_valid = 1; out_ready = 1;
    for (int i = 0; i < 20; i++) begin
      in_row = $urandom;
      @(posedge CLK); #1;
      if (gen_dut[0].ov && gen_dut[0].idx == 1) break;
    end
    check(gen_dut[0].ov && gen_dut[0].idx == 1, "stall reach w1", {gen_dut[0].ov, gen_dut[0].idx}, {1'b1, 3'd1});
    out_ready = 0;
    repeat (5) begin
      @(posedge CLK); #1;
      check(!gen_dut[0].ir && gen_dut[0].ov && gen_dut[0].idx == 1, "stall hold", {gen_dut[0].ir, gen_dut[0].ov, gen_dut[0].idx}, {2'b01, 3'd1});
    end
    out_ready = 1;
    run_until_done(0, "stall frame timeout");
    for (int f = 0; f < 4; f++) begin
      pulse_start();
      run_until_done(1, "random frame timeout");
    end
    // Asynchronous reset in the middle of a frame, then a clean frame from idx 0.
    pulse_start();
    in_valid = 1; out_ready = 1;
    repeat (3) begin
      in_row = $urandom;
      @(posedge CLK); #1;
    end
    #2 RST = 0;
    #1;
    check(!(gen_dut[0].ov | gen_dut[0].first | gen_dut[0].last | gen_dut[0].ir | gen_dut[0].busy | gen_dut[0].fd) &&
          gen_dut[0].win == '0 && gen_dut[0].idx == '0, "async reset",
          {gen_dut[0].ov, gen_dut[0].ir, gen_dut[0].busy, gen_dut[0].win}, 0);
    in_valid = 0;
    repeat (2) @(posedge CLK);
    #1 RST = 1;
    pulse_start();
    run_until_done(0, "post-reset frame timeout");
    in_valid = 1; out_ready = 1;
    repeat (20) begin
      in_row = $urandom;
      @(posedge CLK); #1;
    end
    in_valid = 0;
    repeat (3) @(posedge CLK);
    #1;
    check(!gen_dut[0].active && gen_dut[0].frames > 0, "g0 frames complete", gen_dut[0].frames, 1);
    check(!gen_dut[1].active && gen_dut[1].frames > 0, "g1 frames complete", gen_dut[1].frames, 1);
    check(!gen_dut[2].active && gen_dut[2].frames > 0, "g2 frames complete", gen_dut[2].frames, 1);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
